// File: rtl/program_sequencer_if.sv
// Bundle between the nibble-processor sequencer, its program ROM and the instruction decoder.
// The master modport is the ROM/decoder side; the slave modport is the sequencer.
interface program_sequencer_if #(
    parameter int ADDR_W      = 12,
    parameter int OP_W        = 4,
    parameter int OPRND_W     = 4,
    parameter int STACK_DEPTH = 4
);
    localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);

    logic                      ena;
    logic [OP_W+OPRND_W-1:0]   program_byte;
    logic                      inc_pc;
    logic                      load_pc;
    logic                      call;
    logic                      ret;
    logic [ADDR_W-1:0]         target;
    logic                      clr_err;
    logic [ADDR_W-1:0]         pc;
    logic                      phase;
    logic [OP_W-1:0]           instr;
    logic [OPRND_W-1:0]        oprnd;
    logic [DEPTH_W-1:0]        depth;
    logic                      stack_overflow;
    logic                      stack_underflow;

    modport master (
        output ena, program_byte, inc_pc, load_pc, call, ret, target, clr_err,
        input  pc, phase, instr, oprnd, depth, stack_overflow, stack_underflow
    );

    modport slave (
        input  ena, program_byte, inc_pc, load_pc, call, ret, target, clr_err,
        output pc, phase, instr, oprnd, depth, stack_overflow, stack_underflow
    );
endinterface

// File: rtl/program_sequencer.sv
// Fetch/execute sequencer: program counter, opcode/operand latch, return-address stack
// with call/ret, and sticky stack-error flags.
//
// state   | meaning
// FETCH   | latch opcode/operand from program_byte; decoder controls ignored
// EXECUTE | apply ret > call > load_pc > inc_pc to the pc, then back to FETCH
module program_sequencer #(
    parameter int ADDR_W      = 12,
    parameter int OP_W        = 4,
    parameter int OPRND_W     = 4,
    parameter int STACK_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    program_sequencer_if.slave bus
);
    localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W   = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    typedef enum logic {FETCH = 1'b0, EXECUTE = 1'b1} phase_e;

    phase_e               phase_q, phase_d;
    logic [ADDR_W-1:0]    pc_q, pc_d;
    logic [OP_W-1:0]      instr_q, instr_d;
    logic [OPRND_W-1:0]   oprnd_q, oprnd_d;
    logic [DEPTH_W-1:0]   depth_q, depth_d;
    logic                 ovf_q, ovf_d;
    logic                 unf_q, unf_d;
    logic [ADDR_W-1:0]    stack_q [STACK_DEPTH];

    logic [ADDR_W-1:0]    pc_inc;
    logic [IDX_W-1:0]     push_idx;
    logic [IDX_W-1:0]     top_idx;
    logic                 stack_empty;
    logic                 stack_full;
    logic                 push_en;
    logic                 ovf_set;
    logic                 unf_set;

    // pc+1 wraps naturally at ADDR_W bits, for both increments and pushed return addresses
    assign pc_inc      = pc_q + ADDR_W'(1);
    assign push_idx    = IDX_W'(depth_q);
    assign top_idx     = IDX_W'(depth_q - DEPTH_W'(1));
    assign stack_empty = (depth_q == '0);
    assign stack_full  = (depth_q == DEPTH_W'(STACK_DEPTH));

    always_comb begin
        phase_d = phase_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        oprnd_d = oprnd_q;
        depth_d = depth_q;
        push_en = 1'b0;
        ovf_set = 1'b0;
        unf_set = 1'b0;
        if (bus.ena) begin
            if (phase_q == FETCH) begin
                instr_d = bus.program_byte[OP_W+OPRND_W-1:OPRND_W];
                oprnd_d = bus.program_byte[OPRND_W-1:0];
                phase_d = EXECUTE;
            end else begin
                phase_d = FETCH;
                if (bus.ret) begin
                    if (stack_empty) begin
                        unf_set = 1'b1;
                        pc_d    = pc_inc;
                    end else begin
                        pc_d    = stack_q[top_idx];
                        depth_d = depth_q - DEPTH_W'(1);
                    end
                end else if (bus.call) begin
                    if (stack_full) begin
                        ovf_set = 1'b1;
                        pc_d    = pc_inc;
                    end else begin
                        push_en = 1'b1;
                        pc_d    = bus.target;
                        depth_d = depth_q + DEPTH_W'(1);
                    end
                end else if (bus.load_pc) begin
                    pc_d = bus.target;
                end else if (bus.inc_pc) begin
                    pc_d = pc_inc;
                end
            end
        end
        // a new error on the same edge as clr_err wins, so nothing is lost
        ovf_d = ovf_q;
        unf_d = unf_q;
        if (bus.ena) begin
            ovf_d = (ovf_q & ~bus.clr_err) | ovf_set;
            unf_d = (unf_q & ~bus.clr_err) | unf_set;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= FETCH;
            pc_q    <= '0;
            instr_q <= '0;
            oprnd_q <= '0;
            depth_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            phase_q <= phase_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            oprnd_q <= oprnd_d;
            depth_q <= depth_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // stack storage carries no reset; only entries below depth_q are ever read
    always_ff @(posedge clk) begin
        if (push_en) begin
            stack_q[push_idx] <= pc_inc;
        end
    end

    assign bus.pc              = pc_q;
    assign bus.phase           = (phase_q == EXECUTE);
    assign bus.instr           = instr_q;
    assign bus.oprnd           = oprnd_q;
    assign bus.depth           = depth_q;
    assign bus.stack_overflow  = ovf_q;
    assign bus.stack_underflow = unf_q;
endmodule

// File: tb/tb_program_sequencer.sv
// Directed self-checking bench for program_sequencer with hand-computed expectations.
module tb_program_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_assert = 0;
    int   n_fail = 0;

    program_sequencer_if #(.ADDR_W(12), .OP_W(4), .OPRND_W(4), .STACK_DEPTH(4)) bus ();

    program_sequencer #(.ADDR_W(12), .OP_W(4), .OPRND_W(4), .STACK_DEPTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_ctrl();
        bus.ret = 1'b0; bus.call = 1'b0; bus.load_pc = 1'b0; bus.inc_pc = 1'b0;
        bus.clr_err = 1'b0;
    endtask

    // one full instruction: fetch edge with byte b, execute edge with the given controls
    task automatic run(input logic [7:0] b, input logic r, input logic c, input logic l,
                       input logic i, input logic [11:0] t);
        bus.program_byte = b;
        tick();
        bus.ret = r; bus.call = c; bus.load_pc = l; bus.inc_pc = i; bus.target = t;
        tick();
        clr_ctrl();
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_pc"},    32'(bus.pc), 32'h0);
        chk({tag, "_phase"}, 32'(bus.phase), 32'h0);
        chk({tag, "_instr"}, 32'(bus.instr), 32'h0);
        chk({tag, "_oprnd"}, 32'(bus.oprnd), 32'h0);
        chk({tag, "_depth"}, 32'(bus.depth), 32'h0);
        chk({tag, "_ovf"},   32'(bus.stack_overflow), 32'h0);
        chk({tag, "_unf"},   32'(bus.stack_underflow), 32'h0);
    endtask

    initial begin
        bus.ena = 1'b0;
        bus.program_byte = 8'h00;
        bus.target = 12'h000;
        clr_ctrl();
        tick();
        tick();
        chk_reset("rst");

        // reset release and first fetch
        rst_n = 1'b1;
        bus.ena = 1'b1;
        bus.program_byte = 8'hA5;
        tick();
        chk("fetch_instr", 32'(bus.instr), 32'hA);
        chk("fetch_oprnd", 32'(bus.oprnd), 32'h5);
        chk("fetch_phase", 32'(bus.phase), 32'h1);
        chk("fetch_pc",    32'(bus.pc), 32'h000);
        bus.inc_pc = 1'b1;
        tick();
        chk("exec_pc",    32'(bus.pc), 32'h001);
        chk("exec_phase", 32'(bus.phase), 32'h0);
        chk("exec_instr_held", 32'(bus.instr), 32'hA);

        // freeze during execute with inc_pc held
        bus.program_byte = 8'h3C;
        tick();
        chk("frz_fetch_instr", 32'(bus.instr), 32'h3);
        bus.ena = 1'b0;
        bus.program_byte = 8'hFF;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("frz_pc",    32'(bus.pc), 32'h001);
            chk("frz_phase", 32'(bus.phase), 32'h1);
            chk("frz_instr", 32'(bus.instr), 32'h3);
        end
        bus.ena = 1'b1;
        tick();
        chk("unfrz_pc",    32'(bus.pc), 32'h002);
        chk("unfrz_phase", 32'(bus.phase), 32'h0);
        clr_ctrl();

        // call / return
        run(8'h11, 0, 0, 1, 0, 12'h010);
        chk("load_pc", 32'(bus.pc), 32'h010);
        run(8'h22, 0, 1, 0, 0, 12'h200);
        chk("call_pc",    32'(bus.pc), 32'h200);
        chk("call_depth", 32'(bus.depth), 32'h1);
        run(8'h33, 1, 0, 0, 0, 12'h000);
        chk("ret_pc",    32'(bus.pc), 32'h011);
        chk("ret_depth", 32'(bus.depth), 32'h0);

        // overflow / underflow
        run(8'h40, 0, 1, 0, 0, 12'h100);
        run(8'h41, 0, 1, 0, 0, 12'h200);
        run(8'h42, 0, 1, 0, 0, 12'h300);
        run(8'h43, 0, 1, 0, 0, 12'h400);
        chk("full_depth", 32'(bus.depth), 32'h4);
        chk("full_pc",    32'(bus.pc), 32'h400);
        chk("full_ovf",   32'(bus.stack_overflow), 32'h0);
        run(8'h44, 0, 1, 0, 0, 12'h500);
        chk("ovf_flag",  32'(bus.stack_overflow), 32'h1);
        chk("ovf_pc",    32'(bus.pc), 32'h401);
        chk("ovf_depth", 32'(bus.depth), 32'h4);
        run(8'h50, 1, 0, 0, 0, 12'h000);
        chk("pop1_pc", 32'(bus.pc), 32'h301);
        run(8'h51, 1, 0, 0, 0, 12'h000);
        chk("pop2_pc", 32'(bus.pc), 32'h201);
        run(8'h52, 1, 0, 0, 0, 12'h000);
        chk("pop3_pc", 32'(bus.pc), 32'h101);
        run(8'h53, 1, 0, 0, 0, 12'h000);
        chk("pop4_pc",    32'(bus.pc), 32'h012);
        chk("pop4_depth", 32'(bus.depth), 32'h0);
        chk("pop4_unf",   32'(bus.stack_underflow), 32'h0);
        run(8'h54, 1, 0, 0, 0, 12'h000);
        chk("unf_flag",   32'(bus.stack_underflow), 32'h1);
        chk("unf_pc",     32'(bus.pc), 32'h013);
        chk("unf_depth",  32'(bus.depth), 32'h0);
        chk("ovf_sticky", 32'(bus.stack_overflow), 32'h1);

        // clr_err on a fetch edge, then an execute with no control
        bus.program_byte = 8'h60;
        bus.clr_err = 1'b1;
        tick();
        bus.clr_err = 1'b0;
        chk("clr_ovf",   32'(bus.stack_overflow), 32'h0);
        chk("clr_unf",   32'(bus.stack_underflow), 32'h0);
        chk("clr_phase", 32'(bus.phase), 32'h1);
        tick();
        chk("hold_pc", 32'(bus.pc), 32'h013);

        // clr_err coinciding with a new underflow leaves the flag set
        bus.program_byte = 8'h61;
        tick();
        bus.ret = 1'b1;
        bus.clr_err = 1'b1;
        tick();
        clr_ctrl();
        chk("clr_vs_err_unf", 32'(bus.stack_underflow), 32'h1);
        chk("clr_vs_err_pc",  32'(bus.pc), 32'h014);
        bus.program_byte = 8'h62;
        bus.clr_err = 1'b1;
        tick();
        bus.clr_err = 1'b0;
        tick();
        chk("clr2_unf", 32'(bus.stack_underflow), 32'h0);

        // wrap and priority
        run(8'h70, 0, 0, 1, 0, 12'hFFF);
        chk("wrap_pre", 32'(bus.pc), 32'hFFF);
        run(8'h71, 0, 0, 0, 1, 12'h000);
        chk("wrap_inc", 32'(bus.pc), 32'h000);
        run(8'h72, 0, 0, 1, 0, 12'hFFF);
        run(8'h73, 0, 1, 0, 0, 12'h020);
        chk("wcall_pc",    32'(bus.pc), 32'h020);
        chk("wcall_depth", 32'(bus.depth), 32'h1);
        run(8'h74, 1, 1, 1, 0, 12'h777);
        chk("prio_pc",    32'(bus.pc), 32'h000);
        chk("prio_depth", 32'(bus.depth), 32'h0);
        chk("prio_ovf",   32'(bus.stack_overflow), 32'h0);
        chk("prio_unf",   32'(bus.stack_underflow), 32'h0);
        run(8'h75, 0, 0, 1, 1, 12'h055);
        chk("ld_over_inc", 32'(bus.pc), 32'h055);

        // async reset mid-instruction
        run(8'h80, 0, 1, 0, 0, 12'h050);
        run(8'h81, 0, 1, 0, 0, 12'h060);
        run(8'h82, 0, 0, 1, 0, 12'h123);
        chk("pre_rst_pc",    32'(bus.pc), 32'h123);
        chk("pre_rst_depth", 32'(bus.depth), 32'h2);
        bus.program_byte = 8'h9E;
        tick();
        chk("pre_rst_instr", 32'(bus.instr), 32'h9);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset("arst");
        #3;
        rst_n = 1'b1;
        bus.program_byte = 8'hB7;
        tick();
        chk("post_rst_phase", 32'(bus.phase), 32'h1);
        chk("post_rst_instr", 32'(bus.instr), 32'hB);
        chk("post_rst_pc",    32'(bus.pc), 32'h000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/program_sequencer.md
# program_sequencer

Parametrised fetch/sequencing unit for the nibble-processor family. It holds the program counter and the two-phase fetch/execute toggle, and latches opcode and operand from program memory. It adds what the current fixed 12-bit counter lacks: a return-address stack for call/return, explicit update priority, and sticky stack-error flags. It sits between the program ROM and the instruction decoder, and the decoder drives its control inputs.

## Interface

Parameters:
- ADDR_W, 12, program counter and jump-target width
- OP_W, 4, opcode field width (upper bits of program_byte)
- OPRND_W, 4, operand field width (lower bits of program_byte)
- STACK_DEPTH, 4, return-address stack entries (≥1)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- ena  in  1  advance enable; low freezes all state
- program_byte  in  OP_W+OPRND_W  ROM data at address pc
- inc_pc  in  1  decoder: increment PC (execute phase)
- load_pc  in  1  decoder: jump to target
- call  in  1  decoder: push return address, jump to target
- ret  in  1  decoder: pop return address into PC
- target  in  ADDR_W  jump/call destination
- clr_err  in  1  clears sticky error flags
- pc  out  ADDR_W  program counter (ROM address)
- phase  out  1  0 = fetch, 1 = execute
- instr  out  OP_W  latched opcode
- oprnd  out  OPRND_W  latched operand
- depth  out  clog2(STACK_DEPTH+1)  current stack occupancy
- stack_overflow  out  1  sticky: call attempted while full
- stack_underflow  out  1  sticky: ret attempted while empty

## Operation

- Reset (async, rst_n low) forces: pc=0, phase=0, instr=0, oprnd=0, depth=0, both error flags 0. Stack contents are don't-care.
- All updates occur only on clk edges with ena=1. With ena=0, every register holds.
- Fetch edge (phase=0):
  - instr ← program_byte[OP_W+OPRND_W-1:OPRND_W]; oprnd ← program_byte[OPRND_W-1:0]
  - phase ← 1; pc unchanged
  - Control inputs are ignored.
- Execute edge (phase=1): phase ← 0. The PC update follows strict priority:
  1. ret: if depth>0, pc ← top entry and depth−1. If depth=0, set stack_underflow and pc ← pc+1.
  2. call: if depth<STACK_DEPTH, push pc+1, pc ← target, depth+1. If full, set stack_overflow; no push; pc ← pc+1.
  3. load_pc: pc ← target.
  4. inc_pc: pc ← pc+1.
  5. None asserted: pc holds.
- ret together with call: ret executes and call is ignored entirely (no push, no error).
- Arithmetic: pc+1 is modulo 2^ADDR_W. 2^ADDR_W−1 wraps to 0, both for increments and for pushed return addresses.
- Stack is LIFO: push writes entry[depth], pop reads entry[depth−1].
- Error flags are sticky and cleared by clr_err (takes effect regardless of phase, requires ena=1). If clr_err and a new error occur on the same edge, the flag ends set.

## Timing

- pc is a register output. ROM is combinational, so program_byte must be valid during the fetch cycle.
- Each instruction takes exactly 2 enabled cycles. instr/oprnd are valid for the whole execute cycle and the following fetch cycle.
- Decoder controls are sampled only at the execute edge. The new pc is visible one cycle later, in the next fetch cycle.
- depth and error flags update on the same edge as the causing execute.
- Reset assertion mid-instruction takes effect immediately, without waiting for a clock. After rst_n deasserts, the first enabled edge is a fetch.

## Test plan

- Reset/fetch: hold rst_n=0; release; ROM[0]=8'hA5, ena=1. After the first edge, instr=4'hA, oprnd=4'h5, phase=1, pc=0. After the second edge with inc_pc=1, pc=1, phase=0.
- Ena freeze: toggle ena low for 3 cycles mid-execute with inc_pc=1. pc, phase and instr are unchanged during the freeze. pc increments only on the first enabled execute edge.
- Call/return: pc=12'h010, call with target=12'h200. Result: pc=12'h200, depth=1. Next execute with ret gives pc=12'h011, depth=0.
- Overflow/underflow: 4 nested calls give depth=4. A 5th call gives stack_overflow=1, pc=previous+1, depth=4. 5 rets then give underflow=1 and depth=0. clr_err then clears both flags.
- Priority and wrap: at pc=12'hFFF, assert inc_pc only, which gives pc=12'h000. Assert call+ret+load_pc at depth=1, which gives a pop only with depth=0. Assert load_pc+inc_pc with target=12'h055, which gives pc=12'h055.
- Async reset: assert rst_n low between edges at depth=2, pc=12'h123. All outputs reach reset values before the next clk edge.
